// File: rtl/ddr_wr_rd_arbiter_if.sv
// MIG native user-interface bundle (command, write-data and read-return channels).
// master = arbiter side, slave = memory-controller side.
interface ddr_wr_rd_arbiter_if #(
    parameter int DDR_DATA_WD = 512,
    parameter int DDR_ADDR_WD = 32
);
    logic [DDR_ADDR_WD-1:0] app_addr;
    logic [2:0]             app_cmd;
    logic                   app_en;
    logic                   app_rdy;
    logic [DDR_DATA_WD-1:0] app_wdf_data;
    logic                   app_wdf_wren;
    logic                   app_wdf_end;
    logic                   app_wdf_rdy;
    logic [DDR_DATA_WD-1:0] app_rd_data;
    logic                   app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr_wr_rd_arbiter.sv
// Burst-granular round-robin arbiter sharing one MIG native port between a
// write requester and a read requester; one grant covers BURST_LEN commands.
module ddr_wr_rd_arbiter #(
    parameter int DDR_DATA_WD = 512,
    parameter int DDR_ADDR_WD = 32,
    parameter int BURST_LEN   = 16,
    parameter int ADDR_STEP   = 8
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic                   init_calib_complete,
    input  logic                   wr_req,
    input  logic [DDR_ADDR_WD-1:0] wr_addr,
    input  logic [DDR_DATA_WD-1:0] wr_data,
    output logic                   wr_data_rd,
    output logic                   wr_ack,
    output logic                   wr_done,
    input  logic                   rd_req,
    input  logic [DDR_ADDR_WD-1:0] rd_addr,
    output logic                   rd_ack,
    output logic [DDR_DATA_WD-1:0] rd_data,
    output logic                   rd_data_vld,
    output logic                   rd_done,
    output logic                   busy,
    ddr_wr_rd_arbiter_if.master    app
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR      = 2'd1;
    localparam logic [1:0] S_RD_CMD  = 2'd2;
    localparam logic [1:0] S_RD_WAIT = 2'd3;

    localparam int            CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);

    logic [1:0]             state_reg, state_next;
    logic [CW-1:0]          cmd_cnt_reg, cmd_cnt_next, cmd_cnt_inc;
    logic [CW-1:0]          dat_cnt_reg, dat_cnt_next, dat_cnt_inc;
    logic [CW-1:0]          ret_cnt_reg, ret_cnt_next, ret_cnt_inc;
    logic [DDR_ADDR_WD-1:0] base_reg, base_next;
    logic                   last_rd_reg, last_rd_next;
    logic                   wr_ack_reg, wr_ack_next, rd_ack_reg, rd_ack_next;
    logic                   wr_done_reg, wr_done_next, rd_done_reg, rd_done_next;
    logic [DDR_DATA_WD-1:0] rd_data_reg;
    logic                   rd_data_vld_reg;

    logic in_wr, in_rd_cmd, rd_phase;
    logic cmd_fire, dat_fire, ret_fire;
    logic grant_wr, grant_rd;

    assign in_wr     = (state_reg == S_WR);
    assign in_rd_cmd = (state_reg == S_RD_CMD);
    assign rd_phase  = in_rd_cmd | (state_reg == S_RD_WAIT);

    // Command fields derive only from registered state, so they hold while stalled.
    assign app.app_en       = (in_wr | in_rd_cmd) & (cmd_cnt_reg < BL);
    assign app.app_cmd      = in_rd_cmd ? 3'b001 : 3'b000;
    assign app.app_addr     = base_reg + DDR_ADDR_WD'(cmd_cnt_reg) * DDR_ADDR_WD'(ADDR_STEP);
    assign app.app_wdf_wren = in_wr & (dat_cnt_reg < BL);
    assign app.app_wdf_end  = app.app_wdf_wren;
    assign app.app_wdf_data = wr_data;

    assign cmd_fire = app.app_en & app.app_rdy;
    assign dat_fire = app.app_wdf_wren & app.app_wdf_rdy;
    assign ret_fire = app.app_rd_data_valid & rd_phase & (ret_cnt_reg < BL);

    assign cmd_cnt_inc = cmd_cnt_reg + CW'(cmd_fire);
    assign dat_cnt_inc = dat_cnt_reg + CW'(dat_fire);
    assign ret_cnt_inc = ret_cnt_reg + CW'(ret_fire);

    // Contention goes to whichever side was not served last.
    assign grant_wr = init_calib_complete & wr_req & (~rd_req | last_rd_reg);
    assign grant_rd = init_calib_complete & rd_req & ~grant_wr;

    assign wr_data_rd  = dat_fire;
    assign wr_ack      = wr_ack_reg;
    assign rd_ack      = rd_ack_reg;
    assign wr_done     = wr_done_reg;
    assign rd_done     = rd_done_reg;
    assign rd_data     = rd_data_reg;
    assign rd_data_vld = rd_data_vld_reg;
    assign busy        = (state_reg != S_IDLE);

    always_comb begin
        state_next   = state_reg;
        cmd_cnt_next = cmd_cnt_inc;
        dat_cnt_next = dat_cnt_inc;
        ret_cnt_next = ret_cnt_inc;
        base_next    = base_reg;
        last_rd_next = last_rd_reg;
        wr_ack_next  = 1'b0;
        rd_ack_next  = 1'b0;
        wr_done_next = 1'b0;
        rd_done_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (grant_wr || grant_rd) begin
                    cmd_cnt_next = '0;
                    dat_cnt_next = '0;
                    ret_cnt_next = '0;
                    last_rd_next = grant_rd;
                    base_next    = grant_wr ? wr_addr : rd_addr;
                    state_next   = grant_wr ? S_WR : S_RD_CMD;
                    wr_ack_next  = grant_wr;
                    rd_ack_next  = grant_rd;
                end
            end
            S_WR: begin
                if (cmd_cnt_inc == BL && dat_cnt_inc == BL) begin
                    wr_done_next = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            S_RD_CMD: begin
                if (cmd_cnt_inc == BL) begin
                    if (ret_cnt_inc == BL) begin
                        rd_done_next = 1'b1;
                        state_next   = S_IDLE;
                    end else begin
                        state_next   = S_RD_WAIT;
                    end
                end
            end
            default: begin
                if (ret_cnt_inc == BL) begin
                    rd_done_next = 1'b1;
                    state_next   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg       <= S_IDLE;
            cmd_cnt_reg     <= '0;
            dat_cnt_reg     <= '0;
            ret_cnt_reg     <= '0;
            base_reg        <= '0;
            last_rd_reg     <= 1'b1;
            wr_ack_reg      <= 1'b0;
            rd_ack_reg      <= 1'b0;
            wr_done_reg     <= 1'b0;
            rd_done_reg     <= 1'b0;
            rd_data_reg     <= '0;
            rd_data_vld_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_cnt_reg     <= cmd_cnt_next;
            dat_cnt_reg     <= dat_cnt_next;
            ret_cnt_reg     <= ret_cnt_next;
            base_reg        <= base_next;
            last_rd_reg     <= last_rd_next;
            wr_ack_reg      <= wr_ack_next;
            rd_ack_reg      <= rd_ack_next;
            wr_done_reg     <= wr_done_next;
            rd_done_reg     <= rd_done_next;
            rd_data_vld_reg <= app.app_rd_data_valid & rd_phase;
            if (app.app_rd_data_valid && rd_phase)
                rd_data_reg <= app.app_rd_data;
        end
    end
endmodule

// File: tb/tb_ddr_wr_rd_arbiter.sv
// Randomized bench: a burst-level model of the arbiter plus a MIG stub, compared every cycle.
module tb_ddr_wr_rd_arbiter;
    localparam int DW = 512;
    localparam int AW = 32;
    localparam int BL = 16;
    localparam int STEP = 8;

    logic          clk = 1'b0;
    logic          sys_rst, calib, wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_data_rd, wr_ack, wr_done, rd_ack, rd_data_vld, rd_done, busy;

    ddr_wr_rd_arbiter_if #(.DDR_DATA_WD(DW), .DDR_ADDR_WD(AW)) app ();

    ddr_wr_rd_arbiter #(.DDR_DATA_WD(DW), .DDR_ADDR_WD(AW), .BURST_LEN(BL), .ADDR_STEP(STEP)) dut (
        .clk(clk), .sys_rst(sys_rst), .init_calib_complete(calib),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_data_rd(wr_data_rd),
        .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .rd_data_vld(rd_data_vld), .rd_done(rd_done), .busy(busy), .app(app)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // burst-level model: kind 0 none, 1 write, 2 read
    int            m_kind, m_ncmd, m_ndat, m_nret;
    logic [AW-1:0] m_base;
    bit            m_last_rd;
    bit            e_wack, e_rack, e_wdone, e_rdone, e_vld;
    logic [DW-1:0] e_rdata;
    int            rq[$];
    int            cyc = 0;

    int rdy_pct, wdf_pct, lat, jit;
    bit spur_en;

    int            n_wcmd, n_rcmd, n_pop, n_rvld, n_wdone, n_rdone, rdone_at, n_bursts;
    logic [AW-1:0] first_waddr, last_waddr, first_raddr;
    int            ack_log[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand512();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_kind = 0; m_ncmd = 0; m_ndat = 0; m_nret = 0; m_base = '0; m_last_rd = 1'b1;
        e_wack = 0; e_rack = 0; e_wdone = 0; e_rdone = 0; e_vld = 0; e_rdata = '0;
        rq.delete();
    endtask

    task automatic clear_tally();
        n_wcmd = 0; n_rcmd = 0; n_pop = 0; n_rvld = 0; n_wdone = 0; n_rdone = 0; rdone_at = -1;
        first_waddr = '0; last_waddr = '0; first_raddr = '0;
        ack_log.delete();
    endtask

    // One clock: drive MIG side at negedge, compare, advance the model, then pass the posedge.
    task automatic step();
        logic          en_e, wren_e, ret;
        logic [2:0]    cmd_e;
        logic [AW-1:0] addr_e;
        @(negedge clk);
        cyc++;
        app.app_rdy     = ($urandom_range(99) < rdy_pct);
        app.app_wdf_rdy = ($urandom_range(99) < wdf_pct);
        wr_data         = rand512();
        ret = 1'b0;
        if (rq.size() > 0 && rq[0] <= cyc) begin
            ret = 1'b1;
            void'(rq.pop_front());
        end else if (spur_en && m_kind != 2 && $urandom_range(9) == 0) begin
            ret = 1'b1;
        end
        app.app_rd_data_valid = ret;
        app.app_rd_data       = rand512();
        #1;
        en_e   = (m_kind != 0) && (m_ncmd < BL);
        cmd_e  = (m_kind == 2 && m_ncmd < BL) ? 3'b001 : 3'b000;
        wren_e = (m_kind == 1) && (m_ndat < BL);
        addr_e = m_base + AW'(m_ncmd * STEP);
        chk("busy", busy, m_kind != 0);
        chk("app_en", app.app_en, en_e);
        chk("app_cmd", app.app_cmd, cmd_e);
        if (en_e) chk("app_addr", app.app_addr, addr_e);
        chk("app_wdf_wren", app.app_wdf_wren, wren_e);
        chk("app_wdf_end", app.app_wdf_end, wren_e);
        chk("app_wdf_data", app.app_wdf_data, wr_data);
        chk("wr_data_rd", wr_data_rd, wren_e & app.app_wdf_rdy);
        chk("wr_ack", wr_ack, e_wack);
        chk("rd_ack", rd_ack, e_rack);
        chk("wr_done", wr_done, e_wdone);
        chk("rd_done", rd_done, e_rdone);
        chk("rd_data_vld", rd_data_vld, e_vld);
        if (e_vld) chk("rd_data", rd_data, e_rdata);

        if (wr_ack) ack_log.push_back(0);
        if (rd_ack) ack_log.push_back(1);
        if (app.app_en && app.app_rdy) begin
            if (app.app_cmd == 3'b000) begin
                if (n_wcmd == 0) first_waddr = app.app_addr;
                last_waddr = app.app_addr;
                n_wcmd++;
            end else begin
                if (n_rcmd == 0) first_raddr = app.app_addr;
                n_rcmd++;
            end
        end
        if (wr_data_rd) n_pop++;
        if (rd_data_vld) n_rvld++;
        if (wr_done) begin
            n_wdone++; n_bursts++;
            $display("cycle %0d: write burst %0d complete", cyc, n_bursts);
        end
        if (rd_done) begin
            n_rdone++; n_bursts++; rdone_at = n_rvld;
            $display("cycle %0d: read burst %0d complete", cyc, n_bursts);
        end

        if (sys_rst) begin
            model_reset();
        end else begin
            e_wack = 0; e_rack = 0; e_wdone = 0; e_rdone = 0;
            e_vld   = ret && (m_kind == 2);
            e_rdata = app.app_rd_data;
            case (m_kind)
                0: if (calib && (wr_req || rd_req)) begin
                    if (wr_req && (!rd_req || m_last_rd)) begin
                        m_kind = 1; m_base = wr_addr; m_last_rd = 1'b0; e_wack = 1;
                    end else begin
                        m_kind = 2; m_base = rd_addr; m_last_rd = 1'b1; e_rack = 1;
                    end
                    m_ncmd = 0; m_ndat = 0; m_nret = 0;
                end
                1: begin
                    if (en_e && app.app_rdy) m_ncmd++;
                    if (wren_e && app.app_wdf_rdy) m_ndat++;
                    if (m_ncmd == BL && m_ndat == BL) begin e_wdone = 1; m_kind = 0; end
                end
                2: begin
                    if (en_e && app.app_rdy) begin
                        m_ncmd++;
                        rq.push_back(cyc + lat + int'($urandom_range(jit)));
                    end
                    if (ret && m_nret < BL) m_nret++;
                    if (m_ncmd == BL && m_nret == BL) begin e_rdone = 1; m_kind = 0; end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc && busy; i++) step();
        step();
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        sys_rst = 1'b1; calib = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        app.app_rdy = 1'b0; app.app_wdf_rdy = 1'b0;
        app.app_rd_data = '0; app.app_rd_data_valid = 1'b0;
        rdy_pct = 100; wdf_pct = 100; lat = 10; jit = 0; spur_en = 1'b0; n_bursts = 0;
        model_reset(); clear_tally();
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_app_en", app.app_en, 1'b0);
        sys_rst = 1'b0;

        // single write at 0x1000, no backpressure
        clear_tally();
        wr_addr = 32'h1000; wr_req = 1'b1; step(); wr_req = 1'b0;
        for (int i = 0; i < 200 && n_wdone == 0; i++) step();
        drain(20);
        chk("w1_acks", ack_log.size(), 1);
        chk("w1_ack_kind", ack_log[0], 0);
        chk("w1_ncmd", n_wcmd, 16);
        chk("w1_first_addr", first_waddr, 32'h1000);
        chk("w1_last_addr", last_waddr, 32'h1078);
        chk("w1_pops", n_pop, 16);
        chk("w1_done", n_wdone, 1);

        // single read at 0x2000, returns 10 cycles after each command
        clear_tally();
        rd_addr = 32'h2000; rd_req = 1'b1; step(); rd_req = 1'b0;
        for (int i = 0; i < 300 && n_rdone == 0; i++) step();
        drain(40);
        chk("r1_ncmd", n_rcmd, 16);
        chk("r1_first_addr", first_raddr, 32'h2000);
        chk("r1_vld", n_rvld, 16);
        chk("r1_done", n_rdone, 1);
        chk("r1_done_at_16th", rdone_at, 16);

        // both requests held: grants must alternate starting with write
        clear_tally();
        wr_addr = 32'h0100_0000; rd_addr = 32'h0200_0000;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 600 && ack_log.size() < 4; i++) step();
        wr_req = 1'b0; rd_req = 1'b0;
        drain(100);
        chk("alt_count", ack_log.size(), 4);
        chk("alt_0_wr", ack_log[0], 0);
        chk("alt_1_rd", ack_log[1], 1);
        chk("alt_2_wr", ack_log[2], 0);
        chk("alt_3_rd", ack_log[3], 1);

        // write with 50% backpressure, address wraps past 2^32
        clear_tally();
        rdy_pct = 50; wdf_pct = 50; spur_en = 1'b1;
        wr_addr = 32'hFFFF_FFC0; wr_req = 1'b1; step(); wr_req = 1'b0;
        for (int i = 0; i < 400 && n_wdone == 0; i++) step();
        drain(20);
        chk("bp_ncmd", n_wcmd, 16);
        chk("bp_pops", n_pop, 16);
        chk("bp_done", n_wdone, 1);
        chk("bp_wrap_last_addr", last_waddr, 32'h0000_0038);

        // random traffic against the model
        lat = 3; jit = 8;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) wr_req = ~wr_req;
            if ($urandom_range(19) == 0) rd_req = ~rd_req;
            if ($urandom_range(3) == 0) wr_addr = $urandom;
            if ($urandom_range(3) == 0) rd_addr = $urandom;
            if (calib && $urandom_range(49) == 0) calib = 1'b0;
            else if (!calib && $urandom_range(4) == 0) calib = 1'b1;
            step();
        end
        wr_req = 1'b0; rd_req = 1'b0; calib = 1'b1;
        drain(500);

        // calibration gating after a fresh reset
        rdy_pct = 100; wdf_pct = 100; spur_en = 1'b0;
        sys_rst = 1'b1; step(); step(); sys_rst = 1'b0;
        clear_tally();
        calib = 1'b0; wr_addr = 32'h4000; rd_addr = 32'h5000; wr_req = 1'b1; rd_req = 1'b1;
        repeat (100) step();
        chk("calib_no_ack", ack_log.size(), 0);
        calib = 1'b1;
        for (int i = 0; i < 10 && ack_log.size() == 0; i++) step();
        wr_req = 1'b0; rd_req = 1'b0;
        chk("calib_one_ack", ack_log.size(), 1);
        chk("calib_first_wr", ack_log[0], 0);

        // reset while the 7th write command is presented
        for (int i = 0; i < 100 && n_wcmd < 6; i++) step();
        chk("rst7_addr", app.app_addr, 32'h4030);
        chk("rst7_en", app.app_en, 1'b1);
        sys_rst = 1'b1;
        #1;
        chk("rst7_busy", busy, 1'b0);
        chk("rst7_app_en", app.app_en, 1'b0);
        chk("rst7_wren", app.app_wdf_wren, 1'b0);
        chk("rst7_app_addr", app.app_addr, 32'h0);
        chk("rst7_pop", wr_data_rd, 1'b0);
        model_reset();
        step(); step();
        sys_rst = 1'b0;
        clear_tally();
        wr_addr = 32'h3000; wr_req = 1'b1; step(); wr_req = 1'b0;
        for (int i = 0; i < 200 && n_wdone == 0; i++) step();
        drain(20);
        chk("restart_first_addr", first_waddr, 32'h3000);
        chk("restart_ncmd", n_wcmd, 16);
        chk("restart_done", n_wdone, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
